// File: rtl/ha_stream_initiator.sv
// Word-to-bit sequencer: issues one half-adder bit-pair transaction per bit, LSB first,
// and assembles the returned sum/carry bits. Define HA_INIT_TIMEOUT_EN to abort stalled phases.
module ha_stream_initiator #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic [WIDTH-1:0] res_carry,
  output logic             res_err,
  output logic             ha_valid,
  output logic             ha_a,
  output logic             ha_b,
  input  logic             ha_ready,
  input  logic             ha_rvalid,
  input  logic             ha_sum,
  input  logic             ha_carry,
  output logic             ha_rready
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q, a_n, b_n, sum_n, carry_n;
  logic [IW-1:0]    idx, idx_n, idx_nx;
  logic             cmd_ready_n, ha_valid_n, ha_a_n, ha_b_n, ha_rready_n, res_valid_n, err_n;
  logic             tmo;

`ifdef HA_INIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_n;
  assign tmo = (cnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  assign idx_nx = idx + IW'(1);

  always_comb begin
    state_n     = state;
    a_n         = a_q;
    b_n         = b_q;
    sum_n       = res_sum;
    carry_n     = res_carry;
    idx_n       = idx;
    cmd_ready_n = cmd_ready;
    ha_valid_n  = ha_valid;
    ha_a_n      = ha_a;
    ha_b_n      = ha_b;
    ha_rready_n = ha_rready;
    res_valid_n = res_valid;
    err_n       = res_err;
    case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid) begin
          a_n         = cmd_a;
          b_n         = cmd_b;
          sum_n       = '0;
          carry_n     = '0;
          err_n       = 1'b0;
          idx_n       = '0;
          cmd_ready_n = 1'b0;
          ha_valid_n  = 1'b1;
          ha_a_n      = cmd_a[0];
          ha_b_n      = cmd_b[0];
          state_n     = SEND;
        end
      end
      SEND: begin
        if (ha_valid && ha_ready) begin
          ha_valid_n  = 1'b0;
          ha_rready_n = 1'b1;
          state_n     = WAIT_RSP;
        end else if (tmo) begin
          ha_valid_n  = 1'b0;
          err_n       = 1'b1;
          res_valid_n = 1'b1;
          state_n     = DONE;
        end
      end
      WAIT_RSP: begin
        if (ha_rvalid && ha_rready) begin
          sum_n[idx]   = ha_sum;
          carry_n[idx] = ha_carry;
          ha_rready_n  = 1'b0;
          if (idx == IW'(WIDTH - 1)) begin
            res_valid_n = 1'b1;
            state_n     = DONE;
          end else begin
            idx_n      = idx_nx;
            ha_valid_n = 1'b1;
            ha_a_n     = a_q[idx_nx];
            ha_b_n     = b_q[idx_nx];
            state_n    = SEND;
          end
        end else if (tmo) begin
          ha_rready_n = 1'b0;
          err_n       = 1'b1;
          res_valid_n = 1'b1;
          state_n     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n     = IDLE;
        a_n         = '0;
        b_n         = '0;
        sum_n       = '0;
        carry_n     = '0;
        idx_n       = '0;
        cmd_ready_n = 1'b1;
        ha_valid_n  = 1'b0;
        ha_a_n      = 1'b0;
        ha_b_n      = 1'b0;
        ha_rready_n = 1'b0;
        res_valid_n = 1'b0;
        err_n       = 1'b0;
      end
    endcase
`ifndef HA_INIT_TIMEOUT_EN
    err_n = 1'b0;
`endif
  end

`ifdef HA_INIT_TIMEOUT_EN
  // Counts edges spent in the current handshake phase; any state change restarts it.
  always_comb begin
    cnt_n = '0;
    if ((state_n == state) && ((state == SEND) || (state == WAIT_RSP)))
      cnt_n = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_n;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_sum   <= '0;
      res_carry <= '0;
      idx       <= '0;
      cmd_ready <= 1'b1;
      ha_valid  <= 1'b0;
      ha_a      <= 1'b0;
      ha_b      <= 1'b0;
      ha_rready <= 1'b0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_n;
      a_q       <= a_n;
      b_q       <= b_n;
      res_sum   <= sum_n;
      res_carry <= carry_n;
      idx       <= idx_n;
      cmd_ready <= cmd_ready_n;
      ha_valid  <= ha_valid_n;
      ha_a      <= ha_a_n;
      ha_b      <= ha_b_n;
      ha_rready <= ha_rready_n;
      res_valid <= res_valid_n;
      res_err   <= err_n;
    end
  end
endmodule

// File: tb/tb_ha_stream_initiator.sv
// Scoreboard bench for ha_stream_initiator with a behavioural half-adder responder.
module tb_ha_stream_initiator;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;
  logic         res_valid, res_ready = 1'b1;
  logic [W-1:0] res_sum, res_carry;
  logic         res_err;
  logic         ha_valid, ha_a, ha_b, ha_rready;
  logic         ha_ready = 1'b1, ha_rvalid = 1'b0, ha_sum = 1'b0, ha_carry = 1'b0;

  always #5 clk = ~clk;

  ha_stream_initiator #(.WIDTH(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_carry(res_carry), .res_err(res_err),
    .ha_valid(ha_valid), .ha_a(ha_a), .ha_b(ha_b), .ha_ready(ha_ready),
    .ha_rvalid(ha_rvalid), .ha_sum(ha_sum), .ha_carry(ha_carry), .ha_rready(ha_rready)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic [W-1:0] carry;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;

  // Responder: mode 0 zero-wait, 1 random 0-5 cycle rvalid delay, 2 rvalid stuck on request stuck_req.
  int   mode = 0, stuck_req = -1;
  int   req_cnt = 0, pulses = 0, dly = 0;
  logic prev_v = 1'b0;
  logic a_hist[$];

  initial begin
    forever begin
      @(negedge clk);
      if (ha_valid && !prev_v) pulses++;
      prev_v = ha_valid;
      if (ha_valid && ha_ready) begin
        ha_sum   = ha_a ^ ha_b;
        ha_carry = ha_a & ha_b;
        a_hist.push_back(ha_a);
        req_cnt++;
      end
      case (mode)
        0: ha_rvalid = 1'b1;
        1: begin
          if (ha_rvalid && !ha_rready) begin
            ha_rvalid = 1'b0;
            dly = $urandom_range(0, 5);
          end
          if (ha_rready && !ha_rvalid) begin
            if (dly == 0) ha_rvalid = 1'b1;
            else dly--;
          end
        end
        default: ha_rvalid = (req_cnt != stuck_req);
      endcase
    end
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.sum = a ^ b; e.carry = a & b; e.err = 1'b0;
    return e;
  endfunction

  task automatic send_cmd(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc, output bit to);
    cyc = 0; to = 0;
    while (res_valid !== 1'b1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin to = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if ({ha_valid, ha_a, ha_b, ha_rready, res_valid, res_err} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000", {ha_valid, ha_a, ha_b, ha_rready, res_valid, res_err}); end
    total++; if ({res_sum, res_carry} !== '0) begin
      bad++; $display("FAIL reset_vec got=%h/%h exp=00/00", res_sum, res_carry); end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait;
    int cyc; bit to; int h0; exp_t e; logic [W-1:0] seq;
    mode = 0; res_ready = 1'b1;
    h0 = a_hist.size();
    sb.push_back(model(8'hA5, 8'h0F));
    send_cmd(8'hA5, 8'h0F);
    wait_res(cyc, to);
    total++; if (to || cyc != 16) begin bad++; $display("FAIL zw_latency got=%0d exp=16 to=%0d", cyc, to); end
    e = sb.pop_front();
    total++; if (res_sum !== e.sum || res_carry !== e.carry || res_err !== e.err) begin
      bad++; $display("FAIL zw_result got=%h/%h/%b exp=%h/%h/%b", res_sum, res_carry, res_err, e.sum, e.carry, e.err); end
    seq = '0;
    for (int i = 0; i < W; i++) if (h0 + i < a_hist.size()) seq[i] = a_hist[h0 + i];
    total++; if (a_hist.size() - h0 != W || seq !== 8'hA5) begin
      bad++; $display("FAIL zw_ha_a_seq got=%h n=%0d exp=a5 n=8", seq, a_hist.size() - h0); end
    @(negedge clk);
    total++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL zw_release got=%b%b exp=01", res_valid, cmd_ready); end
  endtask

  task automatic test_random_delay;
    int cyc; bit to; int p0; exp_t e;
    mode = 1; res_ready = 1'b1;
    p0 = pulses;
    sb.push_back(model(8'hFF, 8'hFF));
    send_cmd(8'hFF, 8'hFF);
    wait_res(cyc, to);
    e = sb.pop_front();
    total++; if (to || res_sum !== e.sum || res_carry !== e.carry || res_err !== 1'b0) begin
      bad++; $display("FAIL rnd_result got=%h/%h/%b exp=%h/%h/0 to=%0d", res_sum, res_carry, res_err, e.sum, e.carry, to); end
    total++; if (pulses - p0 != W) begin bad++; $display("FAIL rnd_pulses got=%0d exp=%0d", pulses - p0, W); end
    @(negedge clk);
    mode = 0;
  endtask

  task automatic test_hold_done;
    int cyc; bit to; exp_t e; int errs;
    mode = 0; res_ready = 1'b0;
    sb.push_back(model(8'h12, 8'h34));
    send_cmd(8'h12, 8'h34);
    wait_res(cyc, to);
    e = sb.pop_front();
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin cmd_a = 8'h77; cmd_b = 8'h77; cmd_valid = 1'b1; end
      if (i == 4) cmd_valid = 1'b0;
      if (to || res_valid !== 1'b1 || res_sum !== e.sum || res_carry !== e.carry || cmd_ready !== 1'b0) errs++;
      @(negedge clk);
    end
    total++; if (errs != 0) begin
      bad++; $display("FAIL hold_stable got=%h/%h v=%b rdy=%b exp=%h/%h v=1 rdy=0", res_sum, res_carry, res_valid, cmd_ready, e.sum, e.carry); end
    res_ready = 1'b1;
    @(negedge clk);
    total++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || ha_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got=v%b r%b h%b exp=v0 r1 h0", res_valid, cmd_ready, ha_valid); end
    sb.push_back(model(8'h0F, 8'hF0));
    send_cmd(8'h0F, 8'hF0);
    wait_res(cyc, to);
    e = sb.pop_front();
    total++; if (to || res_sum !== e.sum || res_carry !== e.carry) begin
      bad++; $display("FAIL hold_next got=%h/%h exp=%h/%h", res_sum, res_carry, e.sum, e.carry); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc; bit to; exp_t e;
    mode = 2; stuck_req = req_cnt + 4;
    send_cmd(8'hFF, 8'h00);
    cyc = 0;
    while (!(ha_rready === 1'b1 && req_cnt == stuck_req) && cyc < 100) begin @(negedge clk); cyc++; end
    total++; if (cyc >= 100) begin bad++; $display("FAIL mid_reach_bit3 got=timeout exp=wait_rsp"); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({cmd_ready, ha_valid, ha_a, ha_b, ha_rready, res_valid, res_err} !== 7'b1000000 ||
                 {res_sum, res_carry} !== '0) begin
      bad++; $display("FAIL mid_reset got=%b %h/%h exp=1000000 00/00",
                      {cmd_ready, ha_valid, ha_a, ha_b, ha_rready, res_valid, res_err}, res_sum, res_carry); end
    rst = 1'b0; mode = 0;
    sb.push_back(model(8'h01, 8'h01));
    send_cmd(8'h01, 8'h01);
    wait_res(cyc, to);
    e = sb.pop_front();
    total++; if (to || res_sum !== e.sum || res_carry !== e.carry || res_err !== 1'b0) begin
      bad++; $display("FAIL mid_next got=%h/%h/%b exp=%h/%h/0", res_sum, res_carry, res_err, e.sum, e.carry); end
    @(negedge clk);
  endtask

`ifdef HA_INIT_TIMEOUT_EN
  task automatic test_timeout;
    int cyc; bit to; exp_t e;
    mode = 2; stuck_req = req_cnt + 3; res_ready = 1'b1;
    e.sum = 8'h02; e.carry = 8'h01; e.err = 1'b1;
    sb.push_back(e);
    send_cmd(8'hFF, 8'h01);
    cyc = 0;
    while (!(ha_rready === 1'b1 && req_cnt == stuck_req) && cyc < 100) begin @(negedge clk); cyc++; end
    wait_res(cyc, to);
    total++; if (to || cyc != 15) begin bad++; $display("FAIL tmo_latency got=%0d exp=15 to=%0d", cyc, to); end
    e = sb.pop_front();
    total++; if (res_sum !== e.sum || res_carry !== e.carry || res_err !== e.err) begin
      bad++; $display("FAIL tmo_result got=%h/%h/%b exp=%h/%h/%b", res_sum, res_carry, res_err, e.sum, e.carry, e.err); end
    @(negedge clk);
    mode = 0;
    @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back;
    int cyc; bit to; exp_t e;
    mode = 0; res_ready = 1'b1;
    sb.push_back(model(8'h3C, 8'h5A));
    sb.push_back(model(8'h00, 8'hFF));
    send_cmd(8'h3C, 8'h5A);
    wait_res(cyc, to);
    e = sb.pop_front();
    total++; if (to || res_sum !== e.sum || res_carry !== e.carry || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_first got=%h/%h rdy=%b exp=%h/%h rdy=0", res_sum, res_carry, cmd_ready, e.sum, e.carry); end
    send_cmd(8'h00, 8'hFF);
    wait_res(cyc, to);
    e = sb.pop_front();
    total++; if (to || res_sum !== e.sum || res_carry !== e.carry || res_err !== 1'b0) begin
      bad++; $display("FAIL b2b_second got=%h/%h/%b exp=%h/%h/0", res_sum, res_carry, res_err, e.sum, e.carry); end
    @(negedge clk);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_random_delay;
    test_hold_done;
    test_reset_mid;
`ifdef HA_INIT_TIMEOUT_EN
    test_timeout;
`endif
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ha_stream_initiator.md
# ha_stream_initiator

Initiator-side sequencer for the 1-bit valid/ready half-adder stage. It accepts a WIDTH-bit operand pair on a command handshake and issues one bit-pair transaction per bit position, LSB first, to the half-adder responder. It collects each returned sum/carry bit and presents the assembled XOR/AND vectors on a result handshake. It sits between a word-level stream producer and the bit-serial adder.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- TIMEOUT, 15, cycles allowed per adder handshake phase before abort (≥1; used only with macro)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  operand pair valid
- cmd_ready  out  1  block idle, can accept command
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_sum  out  WIDTH  per-bit sum (A^B)
- res_carry  out  WIDTH  per-bit carry (A&B)
- res_err  out  1  transfer aborted by timeout (constant 0 without macro)
- ha_valid  out  1  bit-pair request valid
- ha_a  out  1  operand A bit
- ha_b  out  1  operand B bit
- ha_ready  in  1  responder accepted request
- ha_rvalid  in  1  responder result valid
- ha_sum  in  1  responder sum bit
- ha_carry  in  1  responder carry bit
- ha_rready  out  1  initiator ready for responder result

## Operation
- All outputs registered. Reset values: cmd_ready=1, ha_valid=0, ha_a=0, ha_b=0, ha_rready=0, res_valid=0, res_err=0, res_sum=0, res_carry=0. State=IDLE, idx=0.
- IDLE: cmd_ready=1. On cmd_valid: latch cmd_a/cmd_b, clear res_sum/res_carry/res_err, idx=0, cmd_ready←0, ha_valid←1, ha_a/ha_b←bit 0 → SEND.
- SEND: ha_valid held high, ha_a/ha_b stable. On ha_valid&&ha_ready: ha_valid←0, ha_rready←1 → WAIT_RSP. ha_ready already high on entry is accepted as the handshake; SEND always lasts ≥1 cycle with ha_valid high.
- WAIT_RSP: ha_rready high. On ha_rvalid&&ha_rready: res_sum[idx]←ha_sum, res_carry[idx]←ha_carry, ha_rready←0. If idx==WIDTH-1: res_valid←1 → DONE. Otherwise idx+1, ha_valid←1, ha_a/ha_b←next bit → SEND.
- DONE: res_valid, res_sum, res_carry, res_err held stable. On res_ready: res_valid←0, cmd_ready←1 → IDLE.
- cmd_valid outside IDLE is ignored. No operand latched.
- ha_rvalid in SEND or IDLE is ignored. ha_ready outside SEND is ignored.
- Unreachable state encodings → IDLE with reset output values.
- rst mid-transfer: all state and outputs return to reset values on the next edge. The partial result is discarded.

## Timing
- Command accept edge E0: cmd_valid&&cmd_ready high at E0.
- Per bit: ≥1 cycle in SEND plus ≥1 cycle in WAIT_RSP.
- With ha_ready and ha_rvalid tied high:
  - bit i is captured at edge E0+2i+2.
  - res_valid is high after edge E0+2·WIDTH.
- Back-to-back: the next command is accepted no earlier than 1 cycle after the res_valid&&res_ready edge.
- ha_a and ha_b change only on edges where ha_valid rises.

## Configuration
- HA_INIT_TIMEOUT_EN defined:
  - A cycle counter clears on every entry to SEND or WAIT_RSP.
  - If a state is still occupied TIMEOUT edges after entry without its handshake: ha_valid←0, ha_rready←0, res_err←1, res_valid←1 → DONE.
  - Bits not yet collected read 0.
- HA_INIT_TIMEOUT_EN undefined:
  - No counter; the block waits indefinitely.
  - res_err is constant 0.

## Test plan
- WIDTH=8, zero-wait responder model, a=0xA5, b=0x0F → res_sum=0xAA, res_carry=0x05, res_err=0; res_valid rises 16 cycles after accept; ha_a sequence LSB-first 1,0,1,0,0,1,0,1.
- Responder model with ha_ready tied 1 and random 0–5 cycle ha_rvalid delay, a=0xFF, b=0xFF → res_sum=0x00, res_carry=0xFF; exactly 8 ha_valid pulses.
- res_ready held low 10 cycles in DONE → res_valid and vectors stable; cmd_valid pulsed meanwhile is ignored (cmd_ready=0); accept follows on res_ready.
- rst asserted 1 cycle while in WAIT_RSP on bit 3 → next cycle all outputs at reset values; a new command a=0x01, b=0x01 → sum=0x00, carry=0x01.
- HA_INIT_TIMEOUT_EN, TIMEOUT=15, ha_rvalid stuck 0 on bit 2 → res_valid, res_err=1 15 edges after WAIT_RSP entry; bits 2–7 of both vectors are 0.
- Back-to-back commands (0x3C,0x5A) then (0x00,0xFF), res_ready=1 → results 0x66/0x18 then 0xFF/0x00.
